// File: rtl/vga_timing_if.sv
// Output bundle of the VGA timing generator: raster counters, decoded
// sync/blanking, pixel strobe and frame bookkeeping.
interface vga_timing_if;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        bright;
    logic        hSync;
    logic        vSync;
    logic        pix_en;
    logic        frame_tick;
    logic [15:0] frame_cnt;

    modport master (
        output hCount, vCount, bright, hSync, vSync,
        output pix_en, frame_tick, frame_cnt
    );

    modport slave (
        input hCount, vCount, bright, hSync, vSync,
        input pix_en, frame_tick, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. A small clock divider produces one pix_en
// strobe per pixel period; horizontal/vertical counters advance on that
// strobe. Sync and visible-window flags are decoded from the counters with
// zero latency, and a one-clk frame_tick marks each frame rollover.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_SYNC      = 96,
    parameter int V_SYNC      = 2,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 783,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 514
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_if.master  vga
);

    localparam logic [1:0] DIV_LAST    = 2'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_C    = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C    = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_LO    = 10'(H_VIS_START);
    localparam logic [9:0] H_VIS_HI    = 10'(H_VIS_END);
    localparam logic [9:0] V_VIS_LO    = 10'(V_VIS_START);
    localparam logic [9:0] V_VIS_HI    = 10'(V_VIS_END);

    logic [1:0]  div_r;
    logic        pix_en_r;
    logic [9:0]  hcount_r;
    logic [9:0]  vcount_r;
    logic        frame_tick_r;
    logic [15:0] frame_cnt_r;

    logic        frame_wrap_s;
    logic        bright_s;
    logic        hsync_s;
    logic        vsync_s;

    // Clock divider: free-running modulo-CLK_DIV counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_r <= 2'd0;
        end else if (div_r == DIV_LAST) begin
            div_r <= 2'd0;
        end else begin
            div_r <= div_r + 2'd1;
        end
    end

    // Pixel strobe: registered so it lands in the cycle after the divider's last count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_en_r <= 1'b0;
        end else begin
            pix_en_r <= (div_r == DIV_LAST);
        end
    end

    // Raster counters: advance one pixel per strobe, line wrap bumps the line counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount_r <= 10'd0;
            vcount_r <= 10'd0;
        end else if (pix_en_r) begin
            if (hcount_r == H_LAST) begin
                hcount_r <= 10'd0;
                if (vcount_r == V_LAST) begin
                    vcount_r <= 10'd0;
                end else begin
                    vcount_r <= vcount_r + 10'd1;
                end
            end else begin
                hcount_r <= hcount_r + 10'd1;
                vcount_r <= vcount_r;
            end
        end else begin
            hcount_r <= hcount_r;
            vcount_r <= vcount_r;
        end
    end

    // Frame rollover: the strobe edge that takes the raster from its last pixel back to (0,0).
    always_comb begin
        frame_wrap_s = 1'b0;
        if (pix_en_r && (hcount_r == H_LAST) && (vcount_r == V_LAST)) begin
            frame_wrap_s = 1'b1;
        end else begin
            frame_wrap_s = 1'b0;
        end
    end

    // Frame bookkeeping: one-clk tick and a free-wrapping frame counter on rollover.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_tick_r <= 1'b0;
            frame_cnt_r  <= 16'd0;
        end else if (frame_wrap_s) begin
            frame_tick_r <= 1'b1;
            frame_cnt_r  <= frame_cnt_r + 16'd1;
        end else begin
            frame_tick_r <= 1'b0;
            frame_cnt_r  <= frame_cnt_r;
        end
    end

    // Zero-latency decodes of the raster position: visible window and active-low syncs.
    always_comb begin
        bright_s = 1'b0;
        hsync_s  = 1'b1;
        vsync_s  = 1'b1;
        if ((hcount_r >= H_VIS_LO) && (hcount_r <= H_VIS_HI) &&
            (vcount_r >= V_VIS_LO) && (vcount_r <= V_VIS_HI)) begin
            bright_s = 1'b1;
        end else begin
            bright_s = 1'b0;
        end
        if (hcount_r < H_SYNC_C) begin
            hsync_s = 1'b0;
        end else begin
            hsync_s = 1'b1;
        end
        if (vcount_r < V_SYNC_C) begin
            vsync_s = 1'b0;
        end else begin
            vsync_s = 1'b1;
        end
    end

    assign vga.hCount     = hcount_r;
    assign vga.vCount     = vcount_r;
    assign vga.bright     = bright_s;
    assign vga.hSync      = hsync_s;
    assign vga.vSync      = vsync_s;
    assign vga.pix_en     = pix_en_r;
    assign vga.frame_tick = frame_tick_r;
    assign vga.frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Uses a scaled-down raster (20x12 pixels, same
// divider) so several full frames fit in a short run. A position-from-time
// model is compared every cycle; directed steps pin specific edges.
module tb_vga_timing_gen;

    localparam int CLK_DIV     = 4;
    localparam int H_TOTAL     = 20;
    localparam int V_TOTAL     = 12;
    localparam int H_SYNC      = 3;
    localparam int V_SYNC      = 2;
    localparam int H_VIS_START = 5;
    localparam int H_VIS_END   = 16;
    localparam int V_VIS_START = 3;
    localparam int V_VIS_END   = 9;
    localparam int FRAME_PIX   = H_TOTAL * V_TOTAL;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   n_clk;
    logic rst_seen;

    vga_timing_if vga_bus ();

    vga_timing_gen #(
        .CLK_DIV     (CLK_DIV),
        .H_TOTAL     (H_TOTAL),
        .V_TOTAL     (V_TOTAL),
        .H_SYNC      (H_SYNC),
        .V_SYNC      (V_SYNC),
        .H_VIS_START (H_VIS_START),
        .H_VIS_END   (H_VIS_END),
        .V_VIS_START (V_VIS_START),
        .V_VIS_END   (V_VIS_END)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vga (vga_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        checks   = 0;
        failures = 0;
        n_clk    = 0;
        rst_seen = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Time base: clks elapsed since the last reset edge.
    always @(posedge clk) begin
        if (!rst) begin
            n_clk    <= 0;
            rst_seen <= 1'b1;
        end else begin
            n_clk    <= n_clk + 1;
        end
    end

    // Every-cycle comparison against the position implied by elapsed time.
    always @(negedge clk) begin
        if (rst_seen) begin
            int k, pos, eh, ev, epix, etick, efc;
            k     = (n_clk == 0) ? 0 : (n_clk - 1) / CLK_DIV;
            pos   = k % FRAME_PIX;
            eh    = pos % H_TOTAL;
            ev    = pos / H_TOTAL;
            epix  = (n_clk > 0 && (n_clk % CLK_DIV) == 0) ? 1 : 0;
            etick = (k > 0 && pos == 0 && ((n_clk - 1) % CLK_DIV) == 0) ? 1 : 0;
            efc   = (k / FRAME_PIX) % 65536;
            chk("model_hCount", int'(vga_bus.hCount), eh);
            chk("model_vCount", int'(vga_bus.vCount), ev);
            chk("model_pix_en", int'(vga_bus.pix_en), epix);
            chk("model_frame_tick", int'(vga_bus.frame_tick), etick);
            chk("model_frame_cnt", int'(vga_bus.frame_cnt), efc);
            chk("model_bright", int'(vga_bus.bright),
                (eh >= H_VIS_START && eh <= H_VIS_END &&
                 ev >= V_VIS_START && ev <= V_VIS_END) ? 1 : 0);
            chk("model_hSync", int'(vga_bus.hSync), (eh >= H_SYNC) ? 1 : 0);
            chk("model_vSync", int'(vga_bus.vSync), (ev >= V_SYNC) ? 1 : 0);
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int h, input int v, input int budget);
        int found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            if (int'(vga_bus.hCount) == h && int'(vga_bus.vCount) == v) begin
                found = 1;
                break;
            end
            tick1();
        end
        chk($sformatf("reach_%0d_%0d", h, v), found, 1);
    endtask

    task automatic pix_gap(output int g);
        g = 0;
        for (int i = 1; i <= 20; i++) begin
            tick1();
            if (vga_bus.pix_en) begin
                g = i;
                break;
            end
        end
    endtask

    task automatic wait_pix_then_edge();
        int found;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (vga_bus.pix_en) begin
                found = 1;
                break;
            end
            tick1();
        end
        chk("pix_en_seen", found, 1);
        tick1();
    endtask

    task automatic bright_at(input int h, input int v, input int exp);
        wait_pos(h, v, 2000);
        chk($sformatf("bright_%0d_%0d", h, v), int'(vga_bus.bright), exp);
    endtask

    initial begin
        int g;
        int lowc;
        int total;
        int found;

        // Reset held three clks.
        rst = 1'b0;
        tick1(); tick1(); tick1();
        chk("rst_hCount", int'(vga_bus.hCount), 0);
        chk("rst_vCount", int'(vga_bus.vCount), 0);
        chk("rst_frame_cnt", int'(vga_bus.frame_cnt), 0);
        chk("rst_frame_tick", int'(vga_bus.frame_tick), 0);
        chk("rst_pix_en", int'(vga_bus.pix_en), 0);
        chk("rst_hSync", int'(vga_bus.hSync), 0);
        chk("rst_vSync", int'(vga_bus.vSync), 0);
        chk("rst_bright", int'(vga_bus.bright), 0);

        // Release: first strobe CLK_DIV clks later, counters idle until then.
        rst = 1'b1;
        g = 0;
        for (int i = 1; i <= 20; i++) begin
            tick1();
            if (vga_bus.pix_en) begin
                g = i;
                break;
            end
            chk("pre_pix_hCount", int'(vga_bus.hCount), 0);
            chk("pre_pix_vCount", int'(vga_bus.vCount), 0);
            chk("pre_pix_frame_cnt", int'(vga_bus.frame_cnt), 0);
            chk("pre_pix_frame_tick", int'(vga_bus.frame_tick), 0);
        end
        chk("first_pix_delay", g, 4);
        tick1();
        chk("hCount_after_first_pix", int'(vga_bus.hCount), 1);
        pix_gap(g);
        pix_gap(g);
        chk("pix_gap_a", g, 4);
        pix_gap(g);
        chk("pix_gap_b", g, 4);

        // hSync low width on line 1.
        wait_pos(0, 1, 2000);
        chk("hSync_at_0", int'(vga_bus.hSync), 0);
        lowc = 0;
        for (int i = 0; i < 200; i++) begin
            if (vga_bus.hSync) break;
            lowc++;
            tick1();
        end
        chk("hSync_low_clks", lowc, 12);
        chk("hSync_rise_hCount", int'(vga_bus.hCount), 3);
        chk("hSync_at_3", int'(vga_bus.hSync), 1);

        // Visible-window edges and a line wrap, in raster order.
        bright_at(10, 2, 0);
        bright_at(10, 3, 1);
        bright_at(4, 5, 0);
        bright_at(5, 5, 1);
        bright_at(16, 5, 1);
        bright_at(17, 5, 0);
        wait_pos(19, 5, 2000);
        wait_pix_then_edge();
        chk("line_wrap_hCount", int'(vga_bus.hCount), 0);
        chk("line_wrap_vCount", int'(vga_bus.vCount), 6);
        bright_at(10, 9, 1);
        bright_at(10, 10, 0);

        // Frame wrap, vSync low width and frame period.
        wait_pos(19, 11, 2000);
        chk("pre_wrap_frame_cnt", int'(vga_bus.frame_cnt), 0);
        wait_pix_then_edge();
        chk("wrap_frame_tick", int'(vga_bus.frame_tick), 1);
        chk("wrap_hCount", int'(vga_bus.hCount), 0);
        chk("wrap_vCount", int'(vga_bus.vCount), 0);
        chk("wrap_frame_cnt", int'(vga_bus.frame_cnt), 1);
        lowc  = 0;
        total = 0;
        for (int i = 0; i < 2000; i++) begin
            if (vga_bus.vSync) break;
            lowc++;
            tick1();
            total++;
        end
        chk("vSync_low_clks", lowc, 160);
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            if (vga_bus.frame_tick) begin
                found = 1;
                break;
            end
            tick1();
            total++;
        end
        chk("next_tick_seen", found, 1);
        chk("frame_period_clks", total, 960);
        chk("second_frame_cnt", int'(vga_bus.frame_cnt), 2);

        // Mid-frame reset in frame 5.
        found = 0;
        for (int i = 0; i < 6000; i++) begin
            if (int'(vga_bus.frame_cnt) == 5) begin
                found = 1;
                break;
            end
            tick1();
        end
        chk("reach_frame_5", found, 1);
        wait_pos(8, 6, 2000);
        chk("mid_rst_frame_cnt_before", int'(vga_bus.frame_cnt), 5);
        rst = 1'b0;
        tick1();
        rst = 1'b1;
        chk("mid_rst_hCount", int'(vga_bus.hCount), 0);
        chk("mid_rst_vCount", int'(vga_bus.vCount), 0);
        chk("mid_rst_frame_cnt", int'(vga_bus.frame_cnt), 0);
        chk("mid_rst_frame_tick", int'(vga_bus.frame_tick), 0);
        chk("mid_rst_pix_en", int'(vga_bus.pix_en), 0);
        tick1(); tick1(); tick1(); tick1();
        chk("resume_pix_en", int'(vga_bus.pix_en), 1);
        tick1();
        chk("resume_hCount", int'(vga_bus.hCount), 1);
        for (int i = 0; i < 200; i++) tick1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, 4: system clocks per pixel; 100 MHz clk gives a 25 MHz pixel rate.
REQ-002 Parameter H_TOTAL, 800: pixel periods per line.
REQ-003 Parameter V_TOTAL, 525: lines per frame.
REQ-004 Parameter H_SYNC, 96: hSync low width in pixels.
REQ-005 Parameter V_SYNC, 2: vSync low width in lines.
REQ-006 Parameters H_VIS_START/H_VIS_END, 144/783: first/last visible hCount, inclusive.
REQ-007 Parameters V_VIS_START/V_VIS_END, 35/514: first/last visible vCount, inclusive.
REQ-008 clk  in  1  system clock; all state changes on the rising edge only.
REQ-009 rst  in  1  reset; synchronous and active-low (rst==0 sampled at a clk rising edge resets the block).
REQ-010 hCount  out  10  horizontal pixel counter, feeds block_controller.hCount.
REQ-011 vCount  out  10  vertical line counter, feeds block_controller.vCount.
REQ-012 bright  out  1  high inside the visible window, feeds block_controller.bright.
REQ-013 hSync  out  1  active-low horizontal sync to the VGA pin.
REQ-014 vSync  out  1  active-low vertical sync to the VGA pin.
REQ-015 pix_en  out  1  one-clk pulse per pixel period.
REQ-016 frame_tick  out  1  one-clk pulse per frame; drives block_controller's game-update (move) clock or enable.
REQ-017 frame_cnt  out  16  frames since reset, modulo 2^16.

Function
REQ-018 Divider: 2-bit counter div increments every clk and wraps at CLK_DIV-1 to 0.
REQ-019 pix_en is registered and equals 1 in the clk cycle after div==CLK_DIV-1, giving exactly one pulse every CLK_DIV clks.
REQ-020 hCount changes only on a clk edge where pix_en==1: it increments, and at H_TOTAL-1 it wraps to 0.
REQ-021 vCount increments on the same edge on which hCount wraps; at V_TOTAL-1 it wraps to 0 on that edge.
REQ-022 Between pix_en pulses, hCount and vCount hold.
REQ-023 bright is a combinational decode of the count registers: 1 iff H_VIS_START<=hCount<=H_VIS_END and V_VIS_START<=vCount<=V_VIS_END.
REQ-024 hSync is 0 iff hCount<H_SYNC; vSync is 0 iff vCount<V_SYNC. Both are combinational decodes with zero latency relative to the counts.
REQ-025 frame_tick is registered: it is 1 for exactly one clk, in the cycle in which the counters first read (0,0) after wrapping from (H_TOTAL-1,V_TOTAL-1).
REQ-026 frame_cnt increments by 1 on the edge that sets frame_tick. It wraps from 65535 to 0 with no flag.
REQ-027 Frame period is exactly CLK_DIV*H_TOTAL*V_TOTAL clks: 1,680,000 with the defaults.
REQ-028 All counters are unsigned. Widths are sufficient for the defaults, and no count exceeds its TOTAL-1.

Reset
REQ-029 When rst==0 at a clk edge, on that edge:
- div, hCount, vCount and frame_cnt go to 0;
- pix_en and frame_tick go to 0.
REQ-030 While in reset, the outputs therefore read hSync=0, vSync=0, bright=0.
REQ-031 Reset mid-frame takes priority over any simultaneous pix_en, line wrap or frame wrap. No frame_tick is emitted for the aborted frame.
REQ-032 Reset itself does not produce frame_tick. After rst returns to 1, the first pix_en occurs CLK_DIV clks later, and hCount reads 1 one clk after that pulse.

Verification
REQ-033 Reset release:
- hold rst=0 for 3 clks, then set rst=1;
- hCount=vCount=0, frame_cnt=0 and frame_tick=0 until the first pix_en;
- pix_en pulses are exactly 4 clks apart.
REQ-034 Line wrap: run to hCount=799, vCount=10; on the next pix_en, hCount=0 and vCount=11 on the same edge.
REQ-035 Frame wrap: run to (799,524), frame_cnt=0.
- Next pix_en gives counts (0,0) and frame_tick=1 for exactly one clk, with frame_cnt=1.
- The next frame_tick arrives exactly 1,680,000 clks later.
REQ-036 Visible-window edges, bright values:
- with vCount=100: hCount 143->0, 144->1, 783->1, 784->0;
- with hCount=300: vCount 34->0, 35->1, 514->1, 515->0.
REQ-037 Sync widths:
- hSync=0 for hCount 0..95 and 1 at 96;
- vSync=0 for vCount 0..1 and 1 at 2;
- sync low-time measured in clks: 384 for hSync, 6400 for vSync.
REQ-038 Mid-frame reset:
- assert rst=0 for one clk at hCount=400, vCount=200, frame_cnt=5;
- next clk reads all counters 0 and frame_tick=0;
- normal counting resumes from (0,0).
